// File: rtl/vc_bit_scan_encoder_pkg.sv
// Shared types and constants for the bit-scan encoder.
package vc_bit_scan_pkg;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_SCAN = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/vc_bit_scan_encoder_if.sv
// Input-vector and output-index handshakes of the bit-scan encoder.
interface vc_bit_scan_encoder_if #(
    parameter int NBITS = 32
);
    localparam int IDX_NBITS = $clog2(NBITS);

    logic                 in_val;
    logic                 in_rdy;
    logic [NBITS-1:0]     in_bits;
    logic                 in_dir;
    logic                 out_val;
    logic                 out_rdy;
    logic [IDX_NBITS-1:0] out_idx;
    logic                 out_last;
    logic                 out_empty;

    // upstream producer / downstream consumer side
    modport master (
        output in_val, in_bits, in_dir, out_rdy,
        input  in_rdy, out_val, out_idx, out_last, out_empty
    );

    // encoder side
    modport slave (
        input  in_val, in_bits, in_dir, out_rdy,
        output in_rdy, out_val, out_idx, out_last, out_empty
    );
endinterface

// File: rtl/vc_bit_scan_encoder_penc.sv
// Combinational priority encoder: highest set bit (MSB-first) or lowest
// set bit (LSB-first). out_idx is 0 when no bit is set.
module vc_param_priority_encoder
    import vc_bit_scan_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int IDX_NBITS = $clog2(NBITS)
) (
    input  logic [NBITS-1:0]     in_bits,
    input  logic                 dir,
    output logic                 out_val,
    output logic [IDX_NBITS-1:0] out_idx
);

    // later loop iterations override earlier ones, so loop order picks the winner
    always_comb begin
        out_val = |in_bits;
        out_idx = '0;
        if (dir == DIR_MSB_FIRST) begin
            for (int i = 0; i < NBITS; i++) begin
                if (in_bits[i]) out_idx = IDX_NBITS'(i);
            end
        end else begin
            for (int i = NBITS - 1; i >= 0; i--) begin
                if (in_bits[i]) out_idx = IDX_NBITS'(i);
            end
        end
    end

endmodule

// File: rtl/vc_bit_scan_encoder.sv
// Sequential bit-scan encoder: accepts a vector, then emits the index of
// every set bit, one per output transfer, MSB-first or LSB-first.
// A final output and a new input may transfer in the same cycle (no bubble).
module vc_bit_scan_encoder #(
    parameter int NBITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_bit_scan_encoder_if.slave  bus
);
    import vc_bit_scan_pkg::*;

    localparam int IDX_NBITS = $clog2(NBITS);

    state_t               state_q, state_d;
    logic [NBITS-1:0]     work_q, work_d;
    logic                 dir_q, dir_d;

    logic                 pe_val;
    logic [IDX_NBITS-1:0] pe_idx;
    logic                 at_most_one;
    logic [NBITS-1:0]     clr_mask;
    logic                 in_xfer;
    logic                 out_xfer;

    vc_param_priority_encoder #(
        .NBITS     (NBITS),
        .IDX_NBITS (IDX_NBITS)
    ) u_penc (
        .in_bits (work_q),
        .dir     (dir_q),
        .out_val (pe_val),
        .out_idx (pe_idx)
    );

    assign at_most_one = ((work_q & (work_q - NBITS'(1))) == '0);
    assign clr_mask    = NBITS'(1) << pe_idx;

    // handshake and index outputs; in_rdy follows out_rdy while scanning
    always_comb begin
        bus.in_rdy    = 1'b0;
        bus.out_val   = 1'b0;
        bus.out_idx   = pe_idx;
        bus.out_last  = at_most_one;
        bus.out_empty = !pe_val;
        if (!reset) begin
            case (state_q)
                STATE_IDLE: bus.in_rdy = 1'b1;
                STATE_SCAN: begin
                    bus.out_val = 1'b1;
                    bus.in_rdy  = at_most_one && bus.out_rdy;
                end
                default: ;
            endcase
        end
    end

    // next state: load on input, clear serviced bit, or retire the vector
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        dir_d    = dir_q;
        in_xfer  = bus.in_val && bus.in_rdy;
        out_xfer = bus.out_val && bus.out_rdy;
        case (state_q)
            STATE_IDLE: begin
                if (in_xfer) begin
                    work_d  = bus.in_bits;
                    dir_d   = bus.in_dir;
                    state_d = STATE_SCAN;
                end
            end
            STATE_SCAN: begin
                if (out_xfer) begin
                    if (!at_most_one) begin
                        work_d = work_q & ~clr_mask;
                    end else if (in_xfer) begin
                        work_d = bus.in_bits;
                        dir_d  = bus.in_dir;
                    end else begin
                        work_d  = '0;
                        state_d = STATE_IDLE;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            work_q  <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: doc/vc_bit_scan_encoder.md
Name: vc_bit_scan_encoder

Overview:
- Sequential, parametrised generalisation of the priority-encoder family.
- Accepts one NBITS-wide vector per val/rdy transaction.
- Emits the index of every set bit, one per output transaction, in a per-transaction selectable order: MSB-first or LSB-first.
- Used for multi-requester wakeup, free-list scans and exception-vector walks, where every set bit needs service and not only the highest-priority one.

Parameters:
- NBITS, 32, input vector width; must be >= 2.
- IDX_NBITS, $clog2(NBITS), output index width. Derived; must not be overridden.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_val  input  1  input vector valid
- in_rdy  output  1  block can accept a vector
- in_bits  input  NBITS  vector to scan
- in_dir  input  1  scan order: 0 = MSB-first, 1 = LSB-first
- out_val  output  1  index valid
- out_rdy  input  1  consumer accepts index
- out_idx  output  IDX_NBITS  bit position of the current set bit
- out_last  output  1  this is the final output for the current vector
- out_empty  output  1  vector was all zeros; out_idx is 0 and meaningless

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high on reset.
- Reset state: state=IDLE, work register=0, dir register=0.
  - While reset is high: in_rdy=0 and out_val=0.
  - Reset asserted mid-scan aborts the scan. Remaining indices are discarded; no output is produced on the cycle after reset.
- Transfers occur only when val && rdy are both high at a clk edge.
- State machine, 2 states:
  - IDLE: in_rdy=1, out_val=0. On an input transfer: work <= in_bits, dir <= in_dir, go to SCAN.
  - SCAN: out_val=1. Outputs are combinational from work and dir:
    - out_idx = position of the highest set bit (dir=0) or lowest set bit (dir=1) of work.
    - out_empty = (work == 0).
    - out_last = (popcount(work) <= 1).
    - On an output transfer with out_last=0: clear bit out_idx in work and stay in SCAN.
    - On an output transfer with out_last=1: go to IDLE, unless an input transfer occurs in the same cycle.
- Back-to-back throughput:
  - In SCAN, in_rdy = out_last && out_rdy. This is a combinational path from out_rdy to in_rdy.
  - If the final output and a new input transfer in the same cycle, load the new vector and remain in SCAN. There is no bubble.
- Latency: the first index appears the cycle after input acceptance. A vector with k set bits occupies max(k,1) output transfers.
- Zero vector: exactly one output with out_empty=1, out_last=1, out_idx=0.
- Index stability: out_idx, out_last and out_empty hold stable while out_val=1 and out_rdy=0.
- dir is sampled only at input acceptance. Changes to in_dir mid-scan have no effect.
- in_bits is sampled only at input acceptance. The upstream may change it freely afterwards.
- Ordering within a vector:
  - dir=0: strictly decreasing indices.
  - dir=1: strictly increasing indices.
- Single set bit at position NBITS-1 or 0: one output with out_last=1.
- Non-power-of-two NBITS:
  - Indices never exceed NBITS-1.
  - Index arithmetic is zero-extended to IDX_NBITS.
- Each output value is independent of out_rdy history, apart from the stall-hold rule above.

Decomposition:
- Shared package vc_bit_scan_pkg:
  - state encoding constants STATE_IDLE=0, STATE_SCAN=1.
  - direction constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1.
- Sub-module vc_param_priority_encoder (combinational):
  - Parameters NBITS, IDX_NBITS.
  - Inputs: in_bits, dir. Outputs: out_val, out_idx.
  - Generalises the fixed 32-to-5 forward and reverse encoders.
  - Instantiated once on the work register.
- The bit-clear mask and the "at most one bit set" test (work & (work-1) == 0) stay in the top module.

Test Plan:
1. Reset, then NBITS=32, in_bits=0x8000_0005, dir=0, out_rdy=1 -> out_idx 31, 2, 0 on consecutive cycles; out_last=1 only on 0; then in_rdy=1 in IDLE.
2. Same vector, dir=1 -> out_idx 0, 2, 31 with out_last on 31; in_dir toggled mid-scan -> order unchanged.
3. in_bits=0, dir=0 -> single output with out_empty=1, out_last=1, out_idx=0; next cycle IDLE.
4. Back-to-back: vector 0x3 then 0x8 presented continuously, out_rdy=1 -> outputs 1, 0, 3 in three consecutive cycles; second vector accepted in the same cycle as output 0.
5. Backpressure: vector 0x0000_0110, out_rdy held 0 for 3 cycles -> out_idx stays 8, out_val stays 1, in_rdy=0; release -> 8, then 4 with out_last=1.
6. Reset mid-scan with NBITS=5 (IDX_NBITS=3): vector 0x1F, reset after the first output -> out_val=0 and in_rdy=0 during reset; post-reset vector 0x10 -> single out_idx=4, out_last=1.
